// File: rtl/multicycle_control.sv
// Main control FSM for the multicycle MIPS datapath. The state decodes the
// opcode over several cycles, and the datapath mux selects and write enables are decoded from that state.
module multicycle_control #(
  parameter logic [5:0] OP_RTYPE = 6'd0,
  parameter logic [5:0] OP_LW    = 6'd35,
  parameter logic [5:0] OP_SW    = 6'd43,
  parameter logic [5:0] OP_BEQ   = 6'd4,
  parameter logic [5:0] OP_J     = 6'd2
) (
  input  logic       clock,
  input  logic       resetN,
  input  logic [5:0] opCode,
  input  logic       memReady,
  output logic       pcWrite,
  output logic       pcWriteCond,
  output logic       iorD,
  output logic       memRead,
  output logic       memWrite,
  output logic       irWrite,
  output logic       memToReg,
  output logic       regDst,
  output logic       regWrite,
  output logic       aluSrcA,
  output logic [1:0] aluSrcB,
  output logic [1:0] aluOp,
  output logic [1:0] pcSource,
  output logic       illegalOp,
  output logic [3:0] state
);

  // state    | meaning
  // FETCH    | read instruction, PC += 4 when memory is ready
  // DECODE   | register read, branch target precompute, dispatch on opcode
  // MEMADDR  | effective address for LW/SW
  // MEMREAD  | load data read, wait for memReady
  // MEMWB    | write MDR to rt
  // MEMWRITE | store data write, wait for memReady
  // EXEC     | R-type ALU operation
  // RTYPEWB  | write ALUOut to rd
  // BRANCH   | compare and conditionally load branch target
  // JUMP     | load jump target
  // IDLE     | post-reset, all outputs low
  typedef enum logic [3:0] {
    S_FETCH    = 4'd0,
    S_DECODE   = 4'd1,
    S_MEMADDR  = 4'd2,
    S_MEMREAD  = 4'd3,
    S_MEMWB    = 4'd4,
    S_MEMWRITE = 4'd5,
    S_EXEC     = 4'd6,
    S_RTYPEWB  = 4'd7,
    S_BRANCH   = 4'd8,
    S_JUMP     = 4'd9,
    S_IDLE     = 4'd10
  } state_t;

  state_t cur_state, nxt_state;

  always_ff @(posedge clock) begin
    if (!resetN) cur_state <= S_IDLE;
    else         cur_state <= nxt_state;
  end

  assign state = cur_state;

  always_comb begin
    nxt_state   = S_IDLE;
    pcWrite     = 1'b0;
    pcWriteCond = 1'b0;
    iorD        = 1'b0;
    memRead     = 1'b0;
    memWrite    = 1'b0;
    irWrite     = 1'b0;
    memToReg    = 1'b0;
    regDst      = 1'b0;
    regWrite    = 1'b0;
    aluSrcA     = 1'b0;
    aluSrcB     = 2'b00;
    aluOp       = 2'b00;
    pcSource    = 2'b00;
    illegalOp   = 1'b0;
    case (cur_state)
      S_IDLE: nxt_state = S_FETCH;
      S_FETCH: begin
        memRead = 1'b1;
        aluSrcB = 2'b01;
        // IR and PC load only on the ready cycle, so each happens once per instruction
        irWrite = memReady;
        pcWrite = memReady;
        nxt_state = memReady ? S_DECODE : S_FETCH;
      end
      S_DECODE: begin
        aluSrcB = 2'b11;
        if (opCode == OP_LW || opCode == OP_SW) nxt_state = S_MEMADDR;
        else if (opCode == OP_RTYPE)           nxt_state = S_EXEC;
        else if (opCode == OP_BEQ)             nxt_state = S_BRANCH;
        else if (opCode == OP_J)               nxt_state = S_JUMP;
        else begin
          nxt_state = S_FETCH;
          illegalOp = 1'b1;
        end
      end
      S_MEMADDR: begin
        aluSrcA   = 1'b1;
        aluSrcB   = 2'b10;
        nxt_state = (opCode == OP_LW) ? S_MEMREAD : S_MEMWRITE;
      end
      S_MEMREAD: begin
        memRead   = 1'b1;
        iorD      = 1'b1;
        nxt_state = memReady ? S_MEMWB : S_MEMREAD;
      end
      S_MEMWB: begin
        regWrite  = 1'b1;
        memToReg  = 1'b1;
        nxt_state = S_FETCH;
      end
      S_MEMWRITE: begin
        memWrite  = 1'b1;
        iorD      = 1'b1;
        nxt_state = memReady ? S_FETCH : S_MEMWRITE;
      end
      S_EXEC: begin
        aluSrcA   = 1'b1;
        aluOp     = 2'b10;
        nxt_state = S_RTYPEWB;
      end
      S_RTYPEWB: begin
        regWrite  = 1'b1;
        regDst    = 1'b1;
        nxt_state = S_FETCH;
      end
      S_BRANCH: begin
        aluSrcA     = 1'b1;
        aluOp       = 2'b01;
        pcWriteCond = 1'b1;
        pcSource    = 2'b01;
        nxt_state   = S_FETCH;
      end
      S_JUMP: begin
        pcWrite   = 1'b1;
        pcSource  = 2'b10;
        nxt_state = S_FETCH;
      end
      default: nxt_state = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Randomized bench for multicycle_control: an instruction-level model expands
// each opcode into its expected per-cycle state/control trace.
module tb_multicycle_control;

  logic       clock = 1'b0;
  logic       resetN;
  logic [5:0] opCode;
  logic       memReady;
  logic       pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite;
  logic       memToReg, regDst, regWrite, aluSrcA, illegalOp;
  logic [1:0] aluSrcB, aluOp, pcSource;
  logic [3:0] state;

  int errors = 0;
  int checks = 0;
  int rw_seen;

  multicycle_control dut (
    .clock(clock), .resetN(resetN), .opCode(opCode), .memReady(memReady),
    .pcWrite(pcWrite), .pcWriteCond(pcWriteCond), .iorD(iorD),
    .memRead(memRead), .memWrite(memWrite), .irWrite(irWrite),
    .memToReg(memToReg), .regDst(regDst), .regWrite(regWrite),
    .aluSrcA(aluSrcA), .aluSrcB(aluSrcB), .aluOp(aluOp),
    .pcSource(pcSource), .illegalOp(illegalOp), .state(state)
  );

  always #5 clock = ~clock;

  // Control word order: pcWrite pcWriteCond iorD memRead memWrite irWrite
  // memToReg regDst regWrite aluSrcA aluSrcB aluOp pcSource illegalOp
  wire [16:0] obs_word = {pcWrite, pcWriteCond, iorD, memRead, memWrite, irWrite,
                          memToReg, regDst, regWrite, aluSrcA, aluSrcB, aluOp,
                          pcSource, illegalOp};

  function automatic logic [16:0] cw(input logic pcw, pcc, iord, mr, mw, irw,
                                     m2r, rdst, rw, asa, input logic [1:0] asb,
                                     aop, psrc, input logic ill);
    return {pcw, pcc, iord, mr, mw, irw, m2r, rdst, rw, asa, asb, aop, psrc, ill};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // Called at posedge+1: drive inputs, check mid-cycle, advance to next posedge+1.
  task automatic run_cycle(input string tag, input logic [3:0] exp_state,
                           input logic [16:0] exp_word, input logic rdy,
                           input logic [5:0] op);
    memReady = rdy;
    opCode   = op;
    #3;
    check({tag, "_state"}, {28'd0, state}, {28'd0, exp_state});
    check({tag, "_ctl"}, {15'd0, obs_word}, {15'd0, exp_word});
    if (regWrite) rw_seen++;
    @(posedge clock);
    #1;
  endtask

  function automatic logic is_legal(input logic [5:0] op);
    return op == 6'd0 || op == 6'd35 || op == 6'd43 || op == 6'd4 || op == 6'd2;
  endfunction

  // Expands one instruction into its expected trace; fst/mst are the number of
  // not-ready cycles in FETCH and in the memory access state.
  task automatic run_instr(input logic [5:0] op, input int fst, input int mst);
    logic [16:0] fetch_w;
    fetch_w = cw(0,0,0,1,0,0,0,0,0,0,2'b01,2'b00,2'b00,0);
    rw_seen = 0;
    for (int i = 0; i < fst; i++)
      run_cycle("fetch_wait", 4'd0, fetch_w, 1'b0, 6'($urandom_range(0, 63)));
    run_cycle("fetch_rdy", 4'd0, fetch_w | cw(1,0,0,0,0,1,0,0,0,0,2'b00,2'b00,2'b00,0),
              1'b1, op);
    run_cycle("decode", 4'd1, cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,!is_legal(op)),
              1'($urandom_range(0, 1)), op);
    case (op)
      6'd35, 6'd43: begin
        run_cycle("memaddr", 4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0),
                  1'($urandom_range(0, 1)), op);
        for (int i = 0; i <= mst; i++) begin
          if (op == 6'd35)
            run_cycle("memread", 4'd3, cw(0,0,1,1,0,0,0,0,0,0,2'b00,2'b00,2'b00,0),
                      i == mst, op);
          else
            run_cycle("memwrite", 4'd5, cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0),
                      i == mst, op);
        end
        if (op == 6'd35)
          run_cycle("memwb", 4'd4, cw(0,0,0,0,0,0,1,0,1,0,2'b00,2'b00,2'b00,0),
                    1'($urandom_range(0, 1)), op);
      end
      6'd0: begin
        run_cycle("exec", 4'd6, cw(0,0,0,0,0,0,0,0,0,1,2'b00,2'b10,2'b00,0),
                  1'($urandom_range(0, 1)), op);
        run_cycle("rtypewb", 4'd7, cw(0,0,0,0,0,0,0,1,1,0,2'b00,2'b00,2'b00,0),
                  1'($urandom_range(0, 1)), op);
      end
      6'd4:
        run_cycle("branch", 4'd8, cw(0,1,0,0,0,0,0,0,0,1,2'b00,2'b01,2'b01,0),
                  1'($urandom_range(0, 1)), op);
      6'd2:
        run_cycle("jump", 4'd9, cw(1,0,0,0,0,0,0,0,0,0,2'b00,2'b00,2'b10,0),
                  1'($urandom_range(0, 1)), op);
      default: ;
    endcase
    check("regwrite_count", rw_seen, (op == 6'd35 || op == 6'd0) ? 1 : 0);
  endtask

  logic [5:0] illegal_ops [6] = '{6'd1, 6'd3, 6'd5, 6'd8, 6'd40, 6'd63};
  logic [5:0] legal_ops   [5] = '{6'd0, 6'd35, 6'd43, 6'd4, 6'd2};

  initial begin
    logic [5:0] op;
    resetN = 1'b0; memReady = 1'b0; opCode = 6'd0;
    repeat (2) @(posedge clock);
    #1;
    resetN = 1'b1;
    run_cycle("reset_idle", 4'd10, 17'd0, 1'b1, 6'd35);

    run_instr(6'd35, 0, 0);
    run_instr(6'd35, 3, 2);
    run_instr(6'd0, 0, 0);
    run_instr(6'd4, 1, 0);
    run_instr(6'd2, 0, 0);
    run_instr(6'd63, 0, 0);
    run_instr(6'd43, 2, 1);

    // Reset during a stalled store: memWrite must drop and nothing is written.
    rw_seen = 0;
    run_cycle("sw_fetch", 4'd0, cw(1,0,0,1,0,1,0,0,0,0,2'b01,2'b00,2'b00,0), 1'b1, 6'd43);
    run_cycle("sw_decode", 4'd1, cw(0,0,0,0,0,0,0,0,0,0,2'b11,2'b00,2'b00,0), 1'b0, 6'd43);
    run_cycle("sw_memaddr", 4'd2, cw(0,0,0,0,0,0,0,0,0,1,2'b10,2'b00,2'b00,0), 1'b0, 6'd43);
    run_cycle("sw_stall", 4'd5, cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, 6'd43);
    resetN = 1'b0;
    run_cycle("sw_stall_rst", 4'd5, cw(0,0,1,0,1,0,0,0,0,0,2'b00,2'b00,2'b00,0), 1'b0, 6'd43);
    run_cycle("midrst_idle", 4'd10, 17'd0, 1'b1, 6'd43);
    resetN = 1'b1;
    run_cycle("midrst_idle2", 4'd10, 17'd0, 1'b1, 6'd43);
    check("midrst_regwrite", rw_seen, 0);
    run_instr(6'd2, 0, 0);

    for (int n = 0; n < 300; n++) begin
      if ($urandom_range(0, 7) == 0) op = illegal_ops[$urandom_range(0, 5)];
      else                           op = legal_ops[$urandom_range(0, 4)];
      run_instr(op, $urandom_range(0, 3), $urandom_range(0, 3));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

endmodule
